// File: rtl/sram_ctrl.sv
// Single-port SRAM array controller: one read or write per handshake,
// registered wordline/bitline sequencing and a one-cycle response pulse.
module sram_ctrl #(
    parameter int ROWS   = 16,
    parameter int ADDR_W = 4,
    parameter int DATA_W = 8
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              req_valid,
    output logic              req_ready,
    input  logic              req_we,
    input  logic [ADDR_W-1:0] req_addr,
    input  logic [DATA_W-1:0] req_wdata,
    output logic              rsp_valid,
    output logic              rsp_we,
    output logic              rsp_err,
    output logic [DATA_W-1:0] rsp_rdata,
    output logic [ROWS-1:0]   wordline,
    output logic              write_enable,
    output logic              read_enable,
    output logic [DATA_W-1:0] bl_in,
    output logic [DATA_W-1:0] blb_in,
    input  logic [DATA_W-1:0] bl_out
);

    typedef enum logic [2:0] {
        IDLE,
        WRITE,
        READ,
        RESP,
        PRE
    } state_t;

    state_t            state_q, state_d;
    logic              req_ready_q, req_ready_d;
    logic              rsp_valid_q, rsp_valid_d;
    logic              rsp_we_q, rsp_we_d;
    logic              rsp_err_q, rsp_err_d;
    logic [DATA_W-1:0] rsp_rdata_q, rsp_rdata_d;
    logic [ROWS-1:0]   wordline_q, wordline_d;
    logic              write_enable_q, write_enable_d;
    logic              read_enable_q, read_enable_d;
    logic [DATA_W-1:0] bl_in_q, bl_in_d;
    logic [DATA_W-1:0] blb_in_q, blb_in_d;
    logic              addr_bad;

    assign addr_bad = 32'(req_addr) >= 32'(ROWS);

    always_comb begin
        state_d        = state_q;
        rsp_valid_d    = 1'b0;
        rsp_we_d       = rsp_we_q;
        rsp_err_d      = rsp_err_q;
        rsp_rdata_d    = rsp_rdata_q;
        wordline_d     = '0;
        write_enable_d = 1'b0;
        read_enable_d  = 1'b0;
        bl_in_d        = '0;
        blb_in_d       = '0;
        unique case (state_q)
            IDLE: begin
                if (req_valid) begin
                    if (addr_bad) begin
                        state_d     = RESP;
                        rsp_valid_d = 1'b1;
                        rsp_we_d    = req_we;
                        rsp_err_d   = 1'b1;
                        rsp_rdata_d = '0;
                    end else begin
                        for (int i = 0; i < ROWS; i++) begin
                            wordline_d[i] = (req_addr == ADDR_W'(i));
                        end
                        if (req_we) begin
                            state_d        = WRITE;
                            write_enable_d = 1'b1;
                            bl_in_d        = req_wdata;
                            blb_in_d       = ~req_wdata;
                        end else begin
                            state_d       = READ;
                            read_enable_d = 1'b1;
                        end
                    end
                end
            end
            WRITE: begin
                state_d     = RESP;
                rsp_valid_d = 1'b1;
                rsp_we_d    = 1'b1;
                rsp_err_d   = 1'b0;
                rsp_rdata_d = '0;
            end
            READ: begin
                // bl_out is valid while the row is gated; capture it here
                state_d     = RESP;
                rsp_valid_d = 1'b1;
                rsp_we_d    = 1'b0;
                rsp_err_d   = 1'b0;
                rsp_rdata_d = bl_out;
            end
            RESP: state_d = PRE;
            PRE:  state_d = IDLE;
            default: state_d = IDLE;
        endcase
        req_ready_d = (state_d == IDLE);
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q        <= IDLE;
            req_ready_q    <= 1'b1;
            rsp_valid_q    <= 1'b0;
            rsp_we_q       <= 1'b0;
            rsp_err_q      <= 1'b0;
            rsp_rdata_q    <= '0;
            wordline_q     <= '0;
            write_enable_q <= 1'b0;
            read_enable_q  <= 1'b0;
            bl_in_q        <= '0;
            blb_in_q       <= '0;
        end else begin
            state_q        <= state_d;
            req_ready_q    <= req_ready_d;
            rsp_valid_q    <= rsp_valid_d;
            rsp_we_q       <= rsp_we_d;
            rsp_err_q      <= rsp_err_d;
            rsp_rdata_q    <= rsp_rdata_d;
            wordline_q     <= wordline_d;
            write_enable_q <= write_enable_d;
            read_enable_q  <= read_enable_d;
            bl_in_q        <= bl_in_d;
            blb_in_q       <= blb_in_d;
        end
    end

    assign req_ready    = req_ready_q;
    assign rsp_valid    = rsp_valid_q;
    assign rsp_we       = rsp_we_q;
    assign rsp_err      = rsp_err_q;
    assign rsp_rdata    = rsp_rdata_q;
    assign wordline     = wordline_q;
    assign write_enable = write_enable_q;
    assign read_enable  = read_enable_q;
    assign bl_in        = bl_in_q;
    assign blb_in       = blb_in_q;

endmodule

// File: tb/tb_sram_ctrl.sv
// Directed bench for sram_ctrl: 16-row and 12-row builds, each
// attached to a behavioural cell array.
module tb_sram_ctrl;

    logic clk;
    logic rst;
    int   tests;
    int   fails;

    logic        req_valid, req_ready, req_we;
    logic [3:0]  req_addr;
    logic [7:0]  req_wdata;
    logic        rsp_valid, rsp_we, rsp_err;
    logic [7:0]  rsp_rdata;
    logic [15:0] wordline;
    logic        write_enable, read_enable;
    logic [7:0]  bl_in, blb_in, bl_out;

    logic        b_req_valid, b_req_ready, b_req_we;
    logic [3:0]  b_req_addr;
    logic [7:0]  b_req_wdata;
    logic        b_rsp_valid, b_rsp_we, b_rsp_err;
    logic [7:0]  b_rsp_rdata;
    logic [11:0] b_wordline;
    logic        b_write_enable, b_read_enable;
    logic [7:0]  b_bl_in, b_blb_in, b_bl_out;

    logic [7:0] mem16 [16];
    logic [7:0] mem12 [12];
    logic [7:0] ref16 [16];

    sram_ctrl #(.ROWS(16), .ADDR_W(4), .DATA_W(8)) u16 (
        .clk(clk), .rst(rst),
        .req_valid(req_valid), .req_ready(req_ready),
        .req_we(req_we), .req_addr(req_addr), .req_wdata(req_wdata),
        .rsp_valid(rsp_valid), .rsp_we(rsp_we), .rsp_err(rsp_err),
        .rsp_rdata(rsp_rdata), .wordline(wordline),
        .write_enable(write_enable), .read_enable(read_enable),
        .bl_in(bl_in), .blb_in(blb_in), .bl_out(bl_out)
    );

    sram_ctrl #(.ROWS(12), .ADDR_W(4), .DATA_W(8)) u12 (
        .clk(clk), .rst(rst),
        .req_valid(b_req_valid), .req_ready(b_req_ready),
        .req_we(b_req_we), .req_addr(b_req_addr), .req_wdata(b_req_wdata),
        .rsp_valid(b_rsp_valid), .rsp_we(b_rsp_we), .rsp_err(b_rsp_err),
        .rsp_rdata(b_rsp_rdata), .wordline(b_wordline),
        .write_enable(b_write_enable), .read_enable(b_read_enable),
        .bl_in(b_bl_in), .blb_in(b_blb_in), .bl_out(b_bl_out)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // cell arrays: rows capture on the clock edge while strobed
    always @(posedge clk) begin
        for (int i = 0; i < 16; i++)
            if (write_enable && wordline[i]) mem16[i] <= bl_in;
        for (int i = 0; i < 12; i++)
            if (b_write_enable && b_wordline[i]) mem12[i] <= b_bl_in;
    end

    always_comb begin
        bl_out = '0;
        for (int i = 0; i < 16; i++)
            if (read_enable && wordline[i]) bl_out = bl_out | mem16[i];
    end

    always_comb begin
        b_bl_out = '0;
        for (int i = 0; i < 12; i++)
            if (b_read_enable && b_wordline[i]) b_bl_out = b_bl_out | mem12[i];
    end

    always @(negedge clk) begin
        if (!$onehot0(wordline) || !$onehot0(b_wordline)) begin
            $display("FAIL onehot0 wl16=%h wl12=%h", wordline, b_wordline);
            fails++;
        end
        if ((read_enable && write_enable) || (b_read_enable && b_write_enable)) begin
            $display("FAIL re_we_excl at %0t", $time);
            fails++;
        end
        if (write_enable && blb_in !== ~bl_in) begin
            $display("FAIL blb16 got %h need %h", blb_in, ~bl_in);
            fails++;
        end
        if (b_write_enable && b_blb_in !== ~b_bl_in) begin
            $display("FAIL blb12 got %h need %h", b_blb_in, ~b_bl_in);
            fails++;
        end
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic test_reset();
        rst = 1'b1;
        tick();
        tick();
        rst = 1'b0;
        tick();
        tests++;
        if (req_ready !== 1'b1 || b_req_ready !== 1'b1) begin
            $display("FAIL reset_ready got %b/%b need 1/1", req_ready, b_req_ready);
            fails++;
        end
        tests++;
        if ({rsp_valid, rsp_we, rsp_err, rsp_rdata} !== 11'h0) begin
            $display("FAIL reset_rsp got %b%b%b %h need 0",
                     rsp_valid, rsp_we, rsp_err, rsp_rdata);
            fails++;
        end
        tests++;
        if ({wordline, write_enable, read_enable, bl_in, blb_in} !== 34'h0) begin
            $display("FAIL reset_array got wl=%h we=%b re=%b bl=%h blb=%h need 0",
                     wordline, write_enable, read_enable, bl_in, blb_in);
            fails++;
        end
    endtask

    task automatic test_write();
        req_valid = 1'b1;
        req_we    = 1'b1;
        req_addr  = 4'd3;
        req_wdata = 8'hA5;
        tick();
        req_valid = 1'b0;
        ref16[3]  = 8'hA5;
        tests++;
        if (wordline !== 16'h0008 || write_enable !== 1'b1 || read_enable !== 1'b0) begin
            $display("FAIL write_ctrl got wl=%h we=%b re=%b need 0008/1/0",
                     wordline, write_enable, read_enable);
            fails++;
        end
        tests++;
        if (bl_in !== 8'hA5 || blb_in !== 8'h5A) begin
            $display("FAIL write_bl got %h/%h need a5/5a", bl_in, blb_in);
            fails++;
        end
        tick();
        tests++;
        if (rsp_valid !== 1'b1 || rsp_we !== 1'b1 || rsp_err !== 1'b0 || rsp_rdata !== 8'h00) begin
            $display("FAIL write_rsp got v=%b we=%b err=%b d=%h need 1/1/0/00",
                     rsp_valid, rsp_we, rsp_err, rsp_rdata);
            fails++;
        end
        tick();
        tick();
    endtask

    task automatic test_read();
        req_valid = 1'b1;
        req_we    = 1'b0;
        req_addr  = 4'd3;
        req_wdata = 8'hFF;
        tick();
        req_valid = 1'b0;
        tests++;
        if (wordline !== 16'h0008 || read_enable !== 1'b1 || write_enable !== 1'b0) begin
            $display("FAIL read_ctrl got wl=%h re=%b we=%b need 0008/1/0",
                     wordline, read_enable, write_enable);
            fails++;
        end
        tick();
        tests++;
        if (rsp_valid !== 1'b1 || rsp_we !== 1'b0 || rsp_rdata !== 8'hA5) begin
            $display("FAIL read_rsp got v=%b we=%b d=%h need 1/0/a5",
                     rsp_valid, rsp_we, rsp_rdata);
            fails++;
        end
        tick();
        tests++;
        if (req_ready !== 1'b0 || rsp_valid !== 1'b0 || rsp_rdata !== 8'hA5) begin
            $display("FAIL read_pre got rdy=%b v=%b d=%h need 0/0/a5",
                     req_ready, rsp_valid, rsp_rdata);
            fails++;
        end
        tick();
        tests++;
        if (req_ready !== 1'b1) begin
            $display("FAIL read_ready got %b need 1", req_ready);
            fails++;
        end
    endtask

    task automatic test_back_to_back();
        logic       ops_we [3];
        logic [3:0] ops_ad [3];
        logic [7:0] ops_wd [3];
        logic [7:0] ops_ex [3];
        logic [15:0] wl_ex;
        ops_we = '{1'b1, 1'b0, 1'b0};
        ops_ad = '{4'd5, 4'd5, 4'd0};
        ops_wd = '{8'h3C, 8'h00, 8'h00};
        ops_ex = '{8'h00, 8'h3C, 8'h00};
        req_valid = 1'b1;
        req_we    = ops_we[0];
        req_addr  = ops_ad[0];
        req_wdata = ops_wd[0];
        for (int k = 0; k < 3; k++) begin
            tick();
            wl_ex = 16'h0001 << ops_ad[k];
            if (k < 2) begin
                req_we    = ops_we[k+1];
                req_addr  = ops_ad[k+1];
                req_wdata = ops_wd[k+1];
            end else begin
                req_valid = 1'b0;
            end
            tests++;
            if (wordline !== wl_ex || write_enable !== ops_we[k] || read_enable !== !ops_we[k]) begin
                $display("FAIL b2b_ctrl%0d got wl=%h we=%b re=%b need %h/%b/%b",
                         k, wordline, write_enable, read_enable, wl_ex, ops_we[k], !ops_we[k]);
                fails++;
            end
            tick();
            tests++;
            if (rsp_valid !== 1'b1 || rsp_we !== ops_we[k] || rsp_rdata !== ops_ex[k]) begin
                $display("FAIL b2b_rsp%0d got v=%b we=%b d=%h need 1/%b/%h",
                         k, rsp_valid, rsp_we, rsp_rdata, ops_we[k], ops_ex[k]);
                fails++;
            end
            tick();
            tests++;
            if (wordline !== 16'h0 || write_enable || read_enable || req_ready !== 1'b0) begin
                $display("FAIL b2b_pre%0d got wl=%h we=%b re=%b rdy=%b need 0/0/0/0",
                         k, wordline, write_enable, read_enable, req_ready);
                fails++;
            end
            tick();
            tests++;
            if (req_ready !== 1'b1) begin
                $display("FAIL b2b_ready%0d got %b need 1", k, req_ready);
                fails++;
            end
        end
        ref16[5] = 8'h3C;
    endtask

    task automatic test_err();
        logic [3:0] bad [2];
        bad = '{4'd13, 4'd12};
        for (int k = 0; k < 2; k++) begin
            b_req_valid = 1'b1;
            b_req_we    = k[0];
            b_req_addr  = bad[k];
            b_req_wdata = 8'hEE;
            tick();
            b_req_valid = 1'b0;
            tests++;
            if (b_rsp_valid !== 1'b1 || b_rsp_err !== 1'b1 || b_rsp_rdata !== 8'h00) begin
                $display("FAIL err_rsp%0d got v=%b err=%b d=%h need 1/1/00",
                         k, b_rsp_valid, b_rsp_err, b_rsp_rdata);
                fails++;
            end
            tests++;
            if (b_wordline !== 12'h0 || b_write_enable || b_read_enable) begin
                $display("FAIL err_lines%0d got wl=%h we=%b re=%b need 0",
                         k, b_wordline, b_write_enable, b_read_enable);
                fails++;
            end
            tick();
            tests++;
            if (b_req_ready !== 1'b0 || b_rsp_valid !== 1'b0 || b_rsp_err !== 1'b1
                || b_wordline !== 12'h0) begin
                $display("FAIL err_pre%0d got rdy=%b v=%b err=%b wl=%h need 0/0/1/0",
                         k, b_req_ready, b_rsp_valid, b_rsp_err, b_wordline);
                fails++;
            end
            tick();
            tests++;
            if (b_req_ready !== 1'b1) begin
                $display("FAIL err_ready%0d got %b need 1", k, b_req_ready);
                fails++;
            end
        end
        b_req_valid = 1'b1;
        b_req_we    = 1'b1;
        b_req_addr  = 4'd11;
        b_req_wdata = 8'h77;
        tick();
        b_req_valid = 1'b0;
        tests++;
        if (b_wordline !== 12'h800 || b_write_enable !== 1'b1) begin
            $display("FAIL row11_ctrl got wl=%h we=%b need 800/1", b_wordline, b_write_enable);
            fails++;
        end
        tick();
        tests++;
        if (b_rsp_valid !== 1'b1 || b_rsp_err !== 1'b0) begin
            $display("FAIL row11_rsp got v=%b err=%b need 1/0", b_rsp_valid, b_rsp_err);
            fails++;
        end
        tick();
        tick();
    endtask

    task automatic test_rst_mid();
        req_valid = 1'b1;
        req_we    = 1'b0;
        req_addr  = 4'd3;
        tick();
        req_valid = 1'b0;
        rst = 1'b1;
        tick();
        rst = 1'b0;
        tests++;
        if ({rsp_valid, rsp_we, rsp_err, rsp_rdata} !== 11'h0 || req_ready !== 1'b1) begin
            $display("FAIL rst_read_rsp got v=%b we=%b err=%b d=%h rdy=%b need 0/0/0/00/1",
                     rsp_valid, rsp_we, rsp_err, rsp_rdata, req_ready);
            fails++;
        end
        tests++;
        if ({wordline, write_enable, read_enable, bl_in, blb_in} !== 34'h0) begin
            $display("FAIL rst_read_array got wl=%h we=%b re=%b need 0",
                     wordline, write_enable, read_enable);
            fails++;
        end
        tick();
        tests++;
        if (rsp_valid !== 1'b0 || req_ready !== 1'b1) begin
            $display("FAIL rst_read_norsp got v=%b rdy=%b need 0/1", rsp_valid, req_ready);
            fails++;
        end
        req_valid = 1'b1;
        req_we    = 1'b1;
        req_addr  = 4'd2;
        req_wdata = 8'hFF;
        tick();
        req_valid = 1'b0;
        rst = 1'b1;
        tick();
        rst = 1'b0;
        ref16[2] = 8'hFF;
        tests++;
        if (rsp_valid !== 1'b0 || write_enable !== 1'b0 || wordline !== 16'h0) begin
            $display("FAIL rst_write_out got v=%b we=%b wl=%h need 0/0/0",
                     rsp_valid, write_enable, wordline);
            fails++;
        end
        req_valid = 1'b1;
        req_we    = 1'b0;
        req_addr  = 4'd2;
        tick();
        req_valid = 1'b0;
        tick();
        tests++;
        if (rsp_valid !== 1'b1 || rsp_rdata !== 8'hFF) begin
            $display("FAIL rst_write_kept got v=%b d=%h need 1/ff", rsp_valid, rsp_rdata);
            fails++;
        end
        tick();
        tick();
    endtask

    task automatic test_stream();
        logic [7:0] exp;
        for (int n = 0; n < 1000; n++) begin
            req_valid = 1'b1;
            req_we    = 1'($urandom_range(1, 0));
            req_addr  = 4'($urandom_range(15, 0));
            req_wdata = 8'($urandom_range(255, 0));
            exp       = req_we ? 8'h00 : ref16[req_addr];
            if (req_we) ref16[req_addr] = req_wdata;
            tick();
            req_valid = 1'b0;
            tick();
            tests++;
            if (rsp_valid !== 1'b1 || rsp_rdata !== exp || rsp_err !== 1'b0) begin
                $display("FAIL stream%0d got v=%b d=%h err=%b need 1/%h/0",
                         n, rsp_valid, rsp_rdata, rsp_err, exp);
                fails++;
            end
            tick();
            tick();
        end
    endtask

    initial begin
        tests = 0;
        fails = 0;
        for (int i = 0; i < 16; i++) begin
            mem16[i] = 8'h00;
            ref16[i] = 8'h00;
        end
        for (int i = 0; i < 12; i++) mem12[i] = 8'h00;
        rst         = 1'b1;
        req_valid   = 1'b0;
        req_we      = 1'b0;
        req_addr    = '0;
        req_wdata   = '0;
        b_req_valid = 1'b0;
        b_req_we    = 1'b0;
        b_req_addr  = '0;
        b_req_wdata = '0;
        test_reset();
        test_write();
        test_read();
        test_back_to_back();
        test_err();
        test_rst_mid();
        test_stream();
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule

// File: doc/sram_ctrl.md
# sram_ctrl

Single-port access controller for a row-organised array of SRAM cells. Accepts one read or write request at a time over a valid/ready handshake. Sequences the array's wordline, write-enable, read-enable and complementary bitlines, and returns read data or a write acknowledge on a one-cycle response pulse. Sits between the core's memory-request logic and the cell array; it is the only block that drives array control lines.

## Interface
- ROWS, 16, number of array rows (words); any value ≥ 2
- ADDR_W, 4, request address width; must satisfy 2^ADDR_W ≥ ROWS
- DATA_W, 8, word width (cells per row)

- clk  in  1  sole clock; all state and the cells update on its rising edge
- rst  in  1  reset, synchronous, active-high
- req_valid  in  1  request present
- req_ready  out  1  controller can accept a request this cycle
- req_we  in  1  1 = write, 0 = read
- req_addr  in  ADDR_W  row address
- req_wdata  in  DATA_W  write data
- rsp_valid  out  1  one-cycle completion pulse, reads and writes
- rsp_we  out  1  echo of req_we for the completing op
- rsp_err  out  1  address ≥ ROWS; no array access was made
- rsp_rdata  out  DATA_W  read data; 0 for writes and errors
- wordline  out  ROWS  one-hot row select, all-zero when idle
- write_enable  out  1  array write strobe
- read_enable  out  1  array read gate
- bl_in  out  DATA_W  true bitlines to cells
- blb_in  out  DATA_W  complement bitlines; always ~bl_in while write_enable=1, else 0
- bl_out  in  DATA_W  shared read bitlines from cells (tri-stated when unselected)

## Operation
- FSM states: IDLE, WRITE, READ, RESP, PRE.
- IDLE:
  - req_ready=1.
  - On req_valid, latch we, addr and wdata.
  - addr ≥ ROWS → RESP with rsp_err=1.
  - Otherwise we=1 → WRITE; we=0 → READ.
- WRITE:
  - wordline[addr]=1, write_enable=1, bl_in=wdata, blb_in=~wdata.
  - The cell row captures on the edge that ends this state.
  - Next state is RESP.
- READ:
  - wordline[addr]=1, read_enable=1.
  - bl_out is registered into the rdata holding register on the edge that ends this state.
  - Next state is RESP.
- RESP: rsp_valid=1 for exactly one cycle; all array controls low; then PRE.
- PRE: recovery cycle. All array controls low, req_ready=0. Guarantees one dead cycle between successive wordline assertions, so bl_out never sees two drivers. Then IDLE.
- Register all array-side outputs and response outputs; no combinational path from req_* to array lines.
- Never assert read_enable and write_enable together. Never assert more than one wordline bit.
- rsp_rdata/rsp_we/rsp_err hold their values until the next RESP; rsp_valid qualifies them.
- No response backpressure; the consumer must take rsp_valid when it pulses.
- req_* are ignored whenever req_ready=0.

## Timing
- Reset values:
  - State IDLE; req_ready=1 in the first cycle after reset.
  - rsp_valid=0, rsp_we=0, rsp_err=0, rsp_rdata=0.
  - wordline=0, write_enable=0, read_enable=0, bl_in=0, blb_in=0.
- Handshake accepted at edge E (state IDLE, req_valid=1):
  - Write: WRITE in cycle E+1 (cell updated at end of E+1); rsp_valid in E+2; PRE in E+3; req_ready=1 in E+4.
  - Read: READ in E+1; rsp_valid with data in E+2; PRE in E+3; req_ready=1 in E+4.
  - Error: rsp_valid + rsp_err in E+1; PRE in E+2; ready in E+3; array lines stay low throughout.
- Throughput: one op per 4 cycles (3 on error).
- Reset mid-operation:
  - rst sampled at any edge → IDLE next cycle with all outputs at reset values; no rsp_valid for the aborted op.
  - If rst is sampled on the edge ending WRITE, the cell write still occurs (cells share that edge). A write aborted before that edge leaves the row unchanged.
- Request held high through RESP/PRE is not consumed until IDLE; back-to-back ops need no idle gap from the requester.

## Test plan
- Reset, then write 0xA5 to addr 3 → in WRITE cycle: wordline=0x0008, write_enable=1, bl_in=0xA5, blb_in=0x5A. rsp_valid=1, rsp_we=1, rsp_rdata=0 two cycles after accept.
- Read addr 3 after that write → READ cycle: read_enable=1, wordline=0x0008. rsp_valid=1, rsp_rdata=0xA5 two cycles after accept; req_ready returns 4 cycles after accept.
- Back-to-back: write 0x3C @5, read @5, read @0 (never written) with req_valid held high → accepts 4 cycles apart; reads return 0x3C then 0x00; wordline/enables are never high in consecutive ops' PRE cycles.
- ROWS=12 build, request addr 13 → rsp_err=1 one cycle after accept; wordline, write_enable, read_enable stay 0; ready again 3 cycles after accept.
- Assert rst during READ → next cycle all outputs at reset values, no rsp_valid. Assert rst on the edge ending WRITE of 0xFF @2 → a subsequent read @2 returns 0xFF.
- Random 1000-op write/read stream against a reference memory model → every rsp_rdata matches. Assertions hold throughout: onehot0(wordline), !(read_enable && write_enable), blb_in == ~bl_in whenever write_enable=1.
